// File: rtl/key_priority_encoder.sv
// Debounced 8-key priority encoder with 74x148-style outputs and a small
// key-press event FIFO for a downstream consumer.
module key_priority_encoder #(
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_n,
    input  logic       ei_n,
    output logic [2:0] a_n,
    output logic       gs_n,
    output logic       eo_n,
    output logic [2:0] evt_code,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic       overflow
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit 8 carries ei_n, bits 7:0 carry key_n.
    logic [8:0]       sync1_reg;
    logic [8:0]       sync2_reg;
    logic [8:0]       cand_reg;
    logic [8:0]       deb_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= '1;
            sync2_reg <= '1;
        end else begin
            sync1_reg <= {ei_n, key_n};
            sync2_reg <= sync1_reg;
        end
    end

    assign cnt_next = cnt_reg + CNT_W'(1);

    // Any change restarts the stability window; the counter parks at CNT_MAX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_reg <= '1;
            deb_reg  <= '1;
            cnt_reg  <= '0;
        end else if (sync2_reg != cand_reg) begin
            cand_reg <= sync2_reg;
            cnt_reg  <= '0;
        end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_next;
            if (cnt_next == CNT_MAX) begin
                deb_reg <= cand_reg;
            end
        end
    end

    logic [2:0] enc_idx;
    logic       any_key;

    // Ascending scan so the highest pressed index wins.
    always_comb begin
        enc_idx = '0;
        any_key = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!deb_reg[i]) begin
                enc_idx = 3'(i);
                any_key = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_n  <= 3'b111;
            gs_n <= 1'b1;
            eo_n <= 1'b1;
        end else if (deb_reg[8]) begin
            a_n  <= 3'b111;
            gs_n <= 1'b1;
            eo_n <= 1'b1;
        end else if (!any_key) begin
            a_n  <= 3'b111;
            gs_n <= 1'b1;
            eo_n <= 1'b0;
        end else begin
            a_n  <= ~enc_idx;
            gs_n <= 1'b0;
            eo_n <= 1'b1;
        end
    end

    typedef enum logic {
        IDLE,
        HELD
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic       push;
    logic [2:0] push_code;
    logic [2:0] last_code_reg;

    assign push_code = ~a_n;

    always_comb begin
        state_next = state_reg;
        push       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!gs_n) begin
                    push       = 1'b1;
                    state_next = HELD;
                end
            end
            HELD: begin
                if (gs_n) begin
                    state_next = IDLE;
                end else if (push_code != last_code_reg) begin
                    push = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            last_code_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (push) begin
                last_code_reg <= push_code;
            end
        end
    end

    logic [2:0] fifo_mem [4];
    logic [1:0] wr_ptr_reg;
    logic [1:0] rd_ptr_reg;
    logic [2:0] count_reg;
    logic       full;
    logic       pop;
    logic       wr_en;

    assign full      = (count_reg == 3'd4);
    assign evt_valid = (count_reg != 3'd0);
    assign pop       = evt_valid & evt_ready;
    // A pop on the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_en     = push & (~full | pop);
    assign evt_code  = evt_valid ? fifo_mem[rd_ptr_reg] : 3'b000;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_mem[wr_ptr_reg] <= push_code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 2'd1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 2'd1;
            end
            case ({wr_en, pop})
                2'b10:   count_reg <= count_reg + 3'd1;
                2'b01:   count_reg <= count_reg - 3'd1;
                default: count_reg <= count_reg;
            endcase
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_key_priority_encoder.sv
// Directed bench for key_priority_encoder (DEBOUNCE_CYCLES=4): stimulus queues
// expected event codes, a negedge monitor checks every popped event.
module tb_key_priority_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] key_n;
    logic       ei_n;
    logic [2:0] a_n;
    logic       gs_n;
    logic       eo_n;
    logic [2:0] evt_code;
    logic       evt_valid;
    logic       evt_ready;
    logic       overflow;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] exp_q[$];

    key_priority_encoder #(.DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_n     (key_n),
        .ei_n      (ei_n),
        .a_n       (a_n),
        .gs_n      (gs_n),
        .eo_n      (eo_n),
        .evt_code  (evt_code),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s = %0h at %0t", name, act, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_enc(input string name, input logic [2:0] ea, input logic eg, input logic ee);
        check({name, ".a_n"}, 32'(a_n), 32'(ea));
        check({name, ".gs_n"}, 32'(gs_n), 32'(eg));
        check({name, ".eo_n"}, 32'(eo_n), 32'(ee));
    endtask

    // Monitor: an event is consumed on any edge where valid and ready are both high.
    initial begin
        logic [2:0] e;
        forever begin
            @(negedge clk);
            if (!rst && evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event got=%0d expected=none at %0t", evt_code, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("evt_code", 32'(evt_code), 32'(e));
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        key_n     = 8'hFF;
        ei_n      = 1'b1;
        evt_ready = 1'b1;
        tick(3);
        check_enc("reset", 3'b111, 1'b1, 1'b1);
        check("reset.evt_valid", 32'(evt_valid), 32'd0);
        check("reset.evt_code", 32'(evt_code), 32'd0);
        check("reset.overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        tick(2);

        // Single key 5 with enable: outputs at exactly 7 cycles, event one later.
        ei_n  = 1'b0;
        key_n = 8'b1101_1111;
        exp_q.push_back(3'd5);
        tick(6);
        check("k5_early.gs_n", 32'(gs_n), 32'd1);
        tick(1);
        check_enc("k5", 3'b010, 1'b0, 1'b1);
        check("k5.evt_valid_pre", 32'(evt_valid), 32'd0);
        tick(1);
        check("k5.evt_valid", 32'(evt_valid), 32'd1);
        check("k5.evt_code", 32'(evt_code), 32'd5);
        key_n = 8'hFF;
        tick(10);
        check_enc("k5_rel", 3'b111, 1'b1, 1'b0);

        // Three-cycle glitch never survives debounce.
        key_n = 8'b1111_1110;
        tick(3);
        key_n = 8'hFF;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            check("glitch.gs_n", 32'(gs_n), 32'd1);
        end

        // Keys 6+2, then 2 alone, then release.
        key_n = 8'b1011_1011;
        exp_q.push_back(3'd6);
        tick(7);
        check_enc("k62", 3'b001, 1'b0, 1'b1);
        tick(3);
        key_n = 8'b1111_1011;
        exp_q.push_back(3'd2);
        tick(7);
        check_enc("k2", 3'b101, 1'b0, 1'b1);
        tick(3);
        key_n = 8'hFF;
        tick(7);
        check_enc("k62_rel", 3'b111, 1'b1, 1'b0);
        tick(3);
        check("k62.drained", 32'(exp_q.size()), 32'd0);

        // Five presses without consumer: fifth dropped, overflow set.
        evt_ready = 1'b0;
        begin
            int keys[5] = '{1, 3, 0, 7, 4};
            for (int i = 0; i < 5; i++) begin
                key_n = ~(8'd1 << keys[i]);
                if (i < 4) exp_q.push_back(3'(keys[i]));
                tick(8);
                key_n = 8'hFF;
                tick(8);
                if (i == 3) check("ovf_before", 32'(overflow), 32'd0);
            end
        end
        check("ovf.overflow", 32'(overflow), 32'd1);
        check("ovf.head", 32'(evt_code), 32'd1);
        evt_ready = 1'b1;
        tick(6);
        check("ovf.evt_valid", 32'(evt_valid), 32'd0);
        check("ovf.drained", 32'(exp_q.size()), 32'd0);
        check("ovf.sticky", 32'(overflow), 32'd1);
        rst = 1'b1;
        tick(2);
        check("ovf.clear", 32'(overflow), 32'd0);
        rst = 1'b0;
        tick(2);

        // Full FIFO with simultaneous push and pop.
        ei_n      = 1'b0;
        evt_ready = 1'b0;
        begin
            int keys[4] = '{2, 5, 6, 1};
            for (int i = 0; i < 4; i++) begin
                key_n = ~(8'd1 << keys[i]);
                exp_q.push_back(3'(keys[i]));
                tick(8);
                key_n = 8'hFF;
                tick(8);
            end
        end
        key_n = 8'b1111_0111;
        exp_q.push_back(3'd3);
        tick(7);
        check("pp.gs_n", 32'(gs_n), 32'd0);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        check("pp.overflow", 32'(overflow), 32'd0);
        check("pp.head", 32'(evt_code), 32'd5);
        key_n = 8'hFF;
        tick(8);
        evt_ready = 1'b1;
        tick(4);
        check("pp.evt_valid", 32'(evt_valid), 32'd0);
        check("pp.drained", 32'(exp_q.size()), 32'd0);
        check("pp.overflow_end", 32'(overflow), 32'd0);

        // Disabled with key 3, then enable, then reset mid-press.
        ei_n  = 1'b1;
        key_n = 8'b1111_0111;
        tick(10);
        check_enc("dis", 3'b111, 1'b1, 1'b1);
        ei_n = 1'b0;
        exp_q.push_back(3'd3);
        tick(7);
        check_enc("en_k3", 3'b100, 1'b0, 1'b1);
        tick(3);
        check("en_k3.drained", 32'(exp_q.size()), 32'd0);
        rst = 1'b1;
        #1;
        check_enc("async_rst", 3'b111, 1'b1, 1'b1);
        check("async_rst.evt_valid", 32'(evt_valid), 32'd0);
        tick(3);
        rst = 1'b0;
        exp_q.push_back(3'd3);
        tick(6);
        check("redeb_early.gs_n", 32'(gs_n), 32'd1);
        tick(1);
        check_enc("redeb", 3'b100, 1'b0, 1'b1);
        tick(3);
        key_n = 8'hFF;
        tick(10);
        check("final.drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
